// File: rtl/axi_write_master.sv
// axi_write_master: single-outstanding AXI4 INCR write burst initiator.
// Issues AW, streams beats from a show-ahead FIFO onto W, then takes B.
module axi_write_master #(
  parameter int ADDR_WIDTH          = 32,
  parameter int WRITE_CHANNEL_WIDTH = 32,
  parameter int WRITE_BURST_LEN     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_write,
  input  logic [ADDR_WIDTH-1:0]          target_write_addr,
  input  logic [WRITE_BURST_LEN-1:0]     target_write_burst_len,
  input  logic [WRITE_CHANNEL_WIDTH-1:0] target_write_data,
  input  logic                           target_write_fifo_empty,
  output logic                           target_write_fifo_pull,
  output logic                           done_write,
  output logic                           write_error,
  input  logic                           AWREADY,
  output logic [ADDR_WIDTH-1:0]          AWADDR,
  output logic                           AWVALID,
  output logic [WRITE_BURST_LEN-1:0]     AWLEN,
  output logic [2:0]                     AWSIZE,
  output logic [1:0]                     AWBURST,
  input  logic                           WREADY,
  output logic                           WVALID,
  output logic [WRITE_CHANNEL_WIDTH-1:0] WDATA,
  output logic                           WLAST,
  input  logic                           BVALID,
  input  logic [1:0]                     BRESP,
  output logic                           BREADY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DONE
  } state_t;

  localparam logic [2:0] LP_SIZE =
    3'($clog2(WRITE_CHANNEL_WIDTH / 8));
  localparam logic [WRITE_BURST_LEN-1:0] LP_ONE =
    WRITE_BURST_LEN'(1);

  state_t                     r_state;
  state_t                     w_next;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [WRITE_BURST_LEN-1:0] r_len;
  logic [WRITE_BURST_LEN-1:0] r_cnt;
  logic                       r_err;

  logic w_data_ph;
  logic w_wvalid;
  logic w_whs;
  logic w_last;
  logic w_b_hs;
  logic w_unused_bresp0;

  assign w_data_ph = (r_state == S_DATA);
  assign w_wvalid  = w_data_ph && !target_write_fifo_empty;
  assign w_whs     = w_wvalid && WREADY;
  assign w_last    = w_wvalid && (r_cnt == r_len);
  assign w_b_hs    = (r_state == S_RESP) && BVALID;
  assign w_unused_bresp0 = BRESP[0];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start_write) w_next = S_ADDR;
      S_ADDR:  if (AWREADY) w_next = S_DATA;
      S_DATA:  if (w_whs && w_last) w_next = S_RESP;
      S_RESP:  if (BVALID) w_next = S_DONE;
      S_DONE:  if (!start_write) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start_write) begin
        r_addr <= target_write_addr;
        r_len  <= target_write_burst_len;
        r_err  <= 1'b0;
      end
      // counter wraps to 0 on the last beat, so len=max never overflows
      if (w_whs) r_cnt <= w_last ? '0 : r_cnt + LP_ONE;
      if (w_b_hs) r_err <= BRESP[1];
    end
  end

  assign AWADDR  = r_addr;
  assign AWLEN   = r_len;
  assign AWVALID = (r_state == S_ADDR);
  assign AWSIZE  = LP_SIZE;
  assign AWBURST = 2'b01;

  assign WVALID  = w_wvalid;
  assign WDATA   = w_data_ph ? target_write_data : '0;
  assign WLAST   = w_last;
  assign target_write_fifo_pull = w_whs;

  assign BREADY      = (r_state == S_RESP);
  assign done_write  = (r_state == S_DONE) && start_write;
  assign write_error = r_err;

endmodule
